// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_fb_arbiter: single-port framebuffer scheduler. Display reads win,    |
// | then the bulk-clear engine, then the req/ack image-processing write port.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_fb_arbiter #(
    parameter int         IMG_W    = 160,
    parameter int         IMG_H    = 120,
    parameter int         X_OFF    = 240,
    parameter int         Y_OFF    = 180,
    parameter int         ADDR_W   = 15,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              pix_active,
    output logic [7:0]        color_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    input  logic              clear_start,
    input  logic [7:0]        clear_value,
    output logic              clear_busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_clr_last = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [10:0]       c_x_lo     = 11'(X_OFF);
    localparam logic [10:0]       c_x_hi     = 11'(X_OFF + IMG_W);
    localparam logic [10:0]       c_y_lo     = 11'(Y_OFF);
    localparam logic [10:0]       c_y_hi     = 11'(Y_OFF + IMG_H);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [7:0]          r_clr_val;
    logic                r_win_d1;
    logic                r_win_d2;
    logic                w_in_win;
    logic [9:0]          w_rel_x;
    logic [9:0]          w_rel_y;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_clr_issue;
    logic                w_wr_grant;

    assign w_in_win = pix_active
                   && ({1'b0, pix_x} >= c_x_lo) && ({1'b0, pix_x} < c_x_hi)
                   && ({1'b0, pix_y} >= c_y_lo) && ({1'b0, pix_y} < c_y_hi);

    assign w_rel_x   = pix_x - 10'(X_OFF);
    assign w_rel_y   = pix_y - 10'(Y_OFF);
    assign w_rd_addr = ADDR_W'(32'(w_rel_y) * 32'(IMG_W) + 32'(w_rel_x));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear writes only happen in slots the display leaves free; a clear_start
    // in IDLE also blocks the write port so the clear begins first.
    always_comb begin
        w_state_next = r_state;
        w_clr_issue  = 1'b0;
        w_wr_grant   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_start) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!w_in_win) begin
                    w_clr_issue = 1'b1;
                    if (r_clr_addr == c_clr_last) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_wr_grant = !w_in_win && (r_state == ST_IDLE) && !clear_start
                  && wr_req && !wr_ack;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            wr_ack     <= 1'b0;
            clear_busy <= 1'b0;
            color_out  <= '0;
            r_clr_addr <= '0;
            r_clr_val  <= '0;
            r_win_d1   <= 1'b0;
            r_win_d2   <= 1'b0;
        end else begin
            r_win_d1   <= w_in_win;
            r_win_d2   <= r_win_d1;
            color_out  <= r_win_d2 ? mem_rdata : BG_COLOR;
            // Stays high through the cycle of the final clear write.
            clear_busy <= (r_state == ST_CLEAR) || (w_state_next == ST_CLEAR);
            mem_we     <= 1'b0;
            wr_ack     <= 1'b0;

            if (r_state == ST_IDLE && clear_start) begin
                r_clr_val  <= clear_value;
                r_clr_addr <= '0;
            end

            if (w_in_win) begin
                mem_addr <= w_rd_addr;
            end else if (w_clr_issue) begin
                mem_addr   <= r_clr_addr;
                mem_wdata  <= r_clr_val;
                mem_we     <= 1'b1;
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end else if (w_wr_grant) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
                mem_we    <= 1'b1;
                wr_ack    <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_fb_arbiter: randomized bench with a cycle-level reference model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vga_fb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  pix_x, pix_y;
    logic        pix_active;
    logic [7:0]  color_out;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        clear_start;
    logic [7:0]  clear_value;
    logic        clear_busy;

    always #20 clock = ~clock;

    vga_fb_arbiter dut (
        .clock(clock), .reset(reset),
        .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
        .color_out(color_out),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clear_start(clear_start), .clear_value(clear_value),
        .clear_busy(clear_busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected outputs for the cycle following each edge.
    bit          m_clearing = 1'b0;
    int          m_clr_next = 0;
    logic [7:0]  m_clr_val  = 8'h00;
    logic        m_ack = 1'b0, m_we = 1'b0, m_busy = 1'b0;
    logic [14:0] m_addr = '0;
    logic [7:0]  m_wdata = '0, m_color = '0;
    bit          winq[$] = '{1'b0, 1'b0};

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  x, y;
        bit  win, was_clearing, grant;
        x = int'(pix_x);
        y = int'(pix_y);
        if (!reset) begin
            m_clearing = 1'b0; m_clr_next = 0; m_clr_val = 8'h00;
            m_ack = 1'b0; m_we = 1'b0; m_busy = 1'b0;
            m_addr = '0; m_wdata = '0; m_color = '0;
            winq = '{1'b0, 1'b0};
        end else begin
            win = pix_active && x >= 240 && x < 400 && y >= 180 && y < 300;
            was_clearing = m_clearing;
            m_color = winq[0] ? mem_rdata : 8'h00;
            void'(winq.pop_front());
            winq.push_back(win);
            grant = 1'b0;
            m_we  = 1'b0;
            if (win) begin
                m_addr = 15'((y - 180) * 160 + (x - 240));
            end else if (m_clearing) begin
                m_addr  = 15'(m_clr_next);
                m_wdata = m_clr_val;
                m_we    = 1'b1;
                m_clr_next++;
                if (m_clr_next == 160 * 120) m_clearing = 1'b0;
            end else if (wr_req && !m_ack && !clear_start) begin
                m_addr  = wr_addr;
                m_wdata = wr_data;
                m_we    = 1'b1;
                grant   = 1'b1;
            end
            if (clear_start && !was_clearing) begin
                m_clearing = 1'b1;
                m_clr_next = 0;
                m_clr_val  = clear_value;
            end
            m_busy = was_clearing || m_clearing;
            m_ack  = grant;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_val("mem_we", mem_we, m_we);
        check_val("mem_addr", mem_addr, m_addr);
        if (m_we) check_val("mem_wdata", mem_wdata, m_wdata);
        check_val("wr_ack", wr_ack, m_ack);
        check_val("clear_busy", clear_busy, m_busy);
        check_val("color_out", color_out, m_color);
    endtask

    task automatic rand_pix(input int active_pct);
        pix_active = ($urandom_range(99) < active_pct);
        pix_x      = 10'(230 + $urandom_range(179));
        pix_y      = 10'(170 + $urandom_range(139));
        mem_rdata  = 8'($urandom);
    endtask

    task automatic set_pix(input int x, input int y, input bit act);
        pix_x = 10'(x); pix_y = 10'(y); pix_active = act;
    endtask

    initial begin
        int n;
        int wr_cnt;
        reset = 1'b0; clear_start = 1'b0; clear_value = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        set_pix(0, 0, 1'b0); mem_rdata = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            rand_pix(80);
            wr_req = 1'($urandom); wr_addr = 15'($urandom); wr_data = 8'($urandom);
            clear_start = 1'($urandom); clear_value = 8'($urandom);
            cycle();
            check_val("rst_we", mem_we, 0);
            check_val("rst_busy", clear_busy, 0);
        end
        clear_start = 1'b0; wr_req = 1'b0;
        set_pix(0, 0, 1'b0);
        reset = 1'b1;
        cycle();

        // Directed display reads
        set_pix(240, 180, 1'b1); cycle();
        check_val("dir_addr0", mem_addr, 0);
        set_pix(241, 181, 1'b1); cycle();
        check_val("dir_addr161", mem_addr, 161);
        set_pix(239, 180, 1'b1); mem_rdata = 8'h11; cycle();
        check_val("dir_color11", color_out, 8'h11);
        set_pix(0, 0, 1'b0); mem_rdata = 8'h5A; cycle();
        check_val("dir_color5a", color_out, 8'h5A);
        mem_rdata = 8'h77; cycle();
        check_val("dir_color_bg", color_out, 8'h00);

        // Write contention with the display window
        wr_req = 1'b1; wr_addr = 15'd100; wr_data = 8'h33;
        for (int i = 0; i < 5; i++) begin
            set_pix(250 + i, 190, 1'b1); cycle();
            check_val("ct_noack", wr_ack, 0);
        end
        set_pix(0, 0, 1'b0); cycle();
        check_val("ct_ack", wr_ack, 1);
        check_val("ct_addr", mem_addr, 100);
        check_val("ct_data", mem_wdata, 8'h33);
        wr_addr = 15'd101; wr_data = 8'h34; cycle();
        check_val("ct_ack_gap", wr_ack, 0);
        cycle();
        check_val("ct_ack2", wr_ack, 1);
        wr_req = 1'b0; cycle();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rand_pix(60);
            if (m_ack || !wr_req) begin
                wr_req  = 1'($urandom);
                wr_addr = 15'($urandom);
                wr_data = 8'($urandom);
            end
            reset = ($urandom_range(299) != 0);
            cycle();
        end
        reset = 1'b1; wr_req = 1'b0; set_pix(0, 0, 1'b0); cycle(); cycle();

        // Full clear started together with an eligible write request
        wr_req = 1'b1; wr_addr = 15'd7; wr_data = 8'h44;
        clear_start = 1'b1; clear_value = 8'hFF; cycle();
        check_val("clr_start_busy", clear_busy, 1);
        clear_start = 1'b0; clear_value = 8'h00;
        n = 0; wr_cnt = 0;
        while (m_clearing && n < 60000) begin
            rand_pix(30);
            cycle();
            if (mem_we === 1'b1 && mem_wdata === 8'hFF) wr_cnt++;
            n++;
        end
        check_val("clr_timeout", n < 60000, 1);
        check_val("clr_count", wr_cnt, 19200);
        set_pix(0, 0, 1'b0); cycle();
        check_val("clr_busy_fall", clear_busy, 0);
        check_val("clr_then_ack", wr_ack, 1);
        wr_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Reset in the middle of a clear, then restart
        clear_start = 1'b1; clear_value = 8'hA5; cycle();
        clear_start = 1'b0;
        n = 0;
        while (m_clr_next != 500 && n < 2000) begin
            cycle();
            n++;
        end
        check_val("mid_timeout", n < 2000, 1);
        reset = 1'b0; cycle();
        check_val("mid_rst_we", mem_we, 0);
        check_val("mid_rst_busy", clear_busy, 0);
        reset = 1'b1; clear_start = 1'b1; clear_value = 8'h3C; cycle();
        clear_start = 1'b0; cycle();
        check_val("restart_addr", mem_addr, 0);
        check_val("restart_we", mem_we, 1);
        check_val("restart_data", mem_wdata, 8'h3C);
        n = 0;
        while (m_clearing && n < 30000) begin
            set_pix(0, 0, 1'b0);
            mem_rdata = 8'($urandom);
            cycle();
            n++;
        end
        check_val("restart_timeout", n < 30000, 1);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Single-port framebuffer scheduler between the VGA timing driver and image memory.
- Converts driver pixel coordinates into framebuffer read addresses for a centred IMG_W x IMG_H image and returns the pixel colour.
- Shares the memory's single port, in priority order: display reads, then a bulk-clear engine, then a req/ack write port used by the image-processing unit.

Parameters:
IMG_W, 160, image width in pixels
IMG_H, 120, image height in pixels
X_OFF, 240, horizontal screen offset of image column 0
Y_OFF, 180, vertical screen offset of image row 0
ADDR_W, 15, framebuffer address width
BG_COLOR, 8'h00, colour output outside the image window

Ports:
clock  in  1  system clock, 25 MHz pixel clock
reset  in  1  synchronous, active-low reset
pix_x  in  10  current pixel x from VGA driver
pix_y  in  10  current pixel y from VGA driver
pix_active  in  1  high in visible region (driver blank output)
color_out  out  8  pixel colour to driver color_in
mem_addr  out  ADDR_W  framebuffer address
mem_wdata  out  8  framebuffer write data
mem_we  out  1  framebuffer write enable
mem_rdata  in  8  framebuffer read data, valid one cycle after mem_addr
wr_req  in  1  write request, held until acked
wr_addr  in  ADDR_W  write address
wr_data  in  8  write data
wr_ack  out  1  one-cycle pulse, write issued this cycle
clear_start  in  1  pulse: start bulk clear
clear_value  in  8  fill value, sampled with clear_start
clear_busy  out  1  bulk clear in progress

Behaviour:
- Reset: clock and reset are fixed as one clock with synchronous active-low reset; all logic is sampled on the rising clock edge. While reset is low at an edge: mem_addr=0, mem_wdata=0, mem_we=0, wr_ack=0, clear_busy=0, color_out=0, FSM=IDLE, clear counter=0, pipeline valid flags=0.
- Window: in_win = pix_active && X_OFF<=pix_x<X_OFF+IMG_W && Y_OFF<=pix_y<Y_OFF+IMG_H.
- Read address: (pix_y-Y_OFF)*IMG_W + (pix_x-X_OFF), truncated to ADDR_W.
- Slot decision, registered on every edge from the inputs of the preceding cycle:
  - Priority 1, display: if in_win, mem_addr=read address, mem_we=0.
  - Priority 2, clear: else if FSM=CLEAR, write clr_addr with the latched clear_value, mem_we=1.
  - Priority 3, write port: else if wr_req && !wr_ack, write wr_addr/wr_data, mem_we=1, wr_ack=1.
  - Otherwise: mem_we=0 and mem_addr holds its value.
- Display pipeline: pixel inputs in cycle N → mem_addr in cycle N+1 → mem_rdata in cycle N+2 → color_out registered, valid in cycle N+3. Fixed latency is 3 clocks.
  - If in_win was 0 for that pixel, color_out=BG_COLOR.
  - The window flag is pipelined alongside the data.
- wr_ack:
  - High during the same cycle that mem_we performs the write.
  - A new grant is blocked while wr_ack is high, so one handshake produces exactly one write; maximum write rate is one per 2 clocks.
  - wr_req is never acked while in_win or FSM=CLEAR.
- Clear FSM:
  - IDLE --clear_start--> CLEAR: latch clear_value, clr_addr=0, clear_busy=1.
  - CLEAR: clr_addr increments only in cycles where a clear write is issued.
  - The write to IMG_W*IMG_H-1 returns the FSM to IDLE; clear_busy falls on the following cycle.
  - clear_start while in CLEAR is ignored.
- Simultaneous events: clear_start arriving in the same cycle as an eligible wr_req → clear starts; the write waits until the clear completes.
- Reset mid-operation: any pending write is abandoned with no ack; a clear in progress aborts with no further writes.

Test Plan:
1. Reset: hold reset=0 for 3 clocks with random inputs → all outputs 0; FSM idle.
2. Display read: pix (240,180) active → next cycle mem_addr=0, mem_we=0. Pix (241,181) → mem_addr=161. mem_rdata=0x5A → color_out=0x5A exactly 3 clocks after the pixel input. Pix (239,180) → color_out=0x00.
3. Write contention: wr_req addr=100 data=0x33 held during window pixels → wr_ack=0. First non-window cycle → mem_we=1, mem_addr=100, mem_wdata=0x33, wr_ack=1 for 1 cycle; exactly one write. Requester's next req → ack no sooner than 2 clocks later.
4. Clear: pix_active=0, clear_start with clear_value=0xFF → 19200 consecutive writes to addresses 0..19199, data 0xFF; clear_busy falls the cycle after the last write. A wr_req raised mid-clear is acked only afterwards.
5. Clear interleaved with display: toggle in_win during the clear → no writes in window cycles; addresses stay strictly sequential with none skipped or repeated; display reads unaffected.
6. Reset mid-clear at clr_addr=500 → next cycle mem_we=0, clear_busy=0. A new clear_start restarts at address 0.
